// File: rtl/status_cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : status_cond_unit_pkg
// Purpose  : Shared ARM condition-code and status-register bit definitions
//            for the EX-stage status consumer and later branch logic.
// Contents : COND_* condition field encodings, SR_* bit indices of the
//            packed {Z,C,N,V} status word.
// Revision : 1.0 - initial release
// ============================================================================
package status_cond_unit_pkg;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions inside the packed status word {Z,C,N,V}
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  typedef logic [3:0] sr_t;

endpackage
`default_nettype wire

// File: rtl/status_cond_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : status_cond_unit_if
// Purpose  : Bundles the EX status write, ID condition check and fail
//            counter signals between the pipeline and the status unit.
// Ports    : master drives ex_s, ex_sr, freeze, id_valid, id_cond, cnt_clr;
//            slave (the status unit) drives cond_pass, carry_out, sr,
//            fail_count. CNT_W must match the unit's CNT_W.
// Revision : 1.0 - initial release
// ============================================================================
interface status_cond_unit_if #(
  parameter int CNT_W = 16
);
  import status_cond_unit_pkg::*;

  logic             ex_s;
  sr_t              ex_sr;
  logic             freeze;
  logic             id_valid;
  logic [3:0]       id_cond;
  logic             cnt_clr;
  logic             cond_pass;
  logic             carry_out;
  sr_t              sr;
  logic [CNT_W-1:0] fail_count;

  modport master (
    output ex_s, ex_sr, freeze, id_valid, id_cond, cnt_clr,
    input  cond_pass, carry_out, sr, fail_count
  );

  modport slave (
    input  ex_s, ex_sr, freeze, id_valid, id_cond, cnt_clr,
    output cond_pass, carry_out, sr, fail_count
  );

endinterface
`default_nettype wire

// File: rtl/status_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Combinational ARM condition evaluation against {Z,C,N,V}.
// Ports    : cond  [3:0] condition field
//            flags [3:0] status word {Z,C,N,V}
//            pass        1 when the instruction may execute
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval
  import status_cond_unit_pkg::*;
(
  input  wire logic [3:0] cond,
  input  wire logic [3:0] flags,
  output logic            pass
);

  logic w_z, w_c, w_n, w_v;

  assign w_z = flags[SR_Z];
  assign w_c = flags[SR_C];
  assign w_n = flags[SR_N];
  assign w_v = flags[SR_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // reserved encoding never executes
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : status_cond_unit
// Purpose  : Owns the architectural status register, returns the stored
//            carry to the ALU, evaluates the ID condition (optionally with
//            same-cycle EX bypass) and counts squashed instructions.
// Ports    : clk, rst (async, active-high)
//            bus.slave - ex_s, ex_sr, freeze, id_valid, id_cond, cnt_clr in;
//                        cond_pass, carry_out, sr, fail_count out
// Params   : BYPASS - 1: condition sees EX flags written this cycle
//            CNT_W  - fail counter width (must match the interface)
// Revision : 1.0 - initial release
// ============================================================================
module status_cond_unit
  import status_cond_unit_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
)(
  input  wire logic         clk,
  input  wire logic         rst,
  status_cond_unit_if.slave bus
);

  sr_t              r_sr;
  logic [CNT_W-1:0] r_fail_count;
  sr_t              w_feff;
  logic             w_wr;
  logic             w_pass;
  logic             w_fail;

  assign w_wr = bus.ex_s & ~bus.freeze;

  // Effective flags: a flag-setting EX instruction directly ahead of a
  // conditional ID instruction is visible without waiting for the write.
  generate
    if (BYPASS) begin : g_bypass
      assign w_feff = w_wr ? bus.ex_sr : r_sr;
    end else begin : g_no_bypass
      assign w_feff = r_sr;
    end
  endgenerate

  cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .flags (w_feff),
    .pass  (w_pass)
  );

  assign w_fail = bus.id_valid & ~w_pass & ~bus.freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (w_wr) begin
      r_sr <= bus.ex_sr;
    end
  end

  // Clear wins over freeze; increment saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_count <= '0;
    end else if (bus.cnt_clr) begin
      r_fail_count <= '0;
    end else if (w_fail && (r_fail_count != {CNT_W{1'b1}})) begin
      r_fail_count <= r_fail_count + 1'b1;
    end
  end

  // Carry is never bypassed: EX consumes the carry of earlier instructions.
  assign bus.carry_out  = r_sr[SR_C];
  assign bus.sr         = r_sr;
  assign bus.cond_pass  = w_pass;
  assign bus.fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_cond_unit
// Purpose  : Scoreboard bench for status_cond_unit. Three instances:
//            main (BYPASS=1, CNT_W=16), nb (BYPASS=0), c4 (CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_cond_unit;
    import status_cond_unit_pkg::*;

    localparam int SEL_M  = 0;
    localparam int SEL_NB = 1;
    localparam int SEL_C4 = 2;
    localparam int F_PASS = 0;
    localparam int F_CY   = 1;
    localparam int F_SR   = 2;
    localparam int F_CNT  = 3;

    logic clk;
    logic rst;

    status_cond_unit_if #(.CNT_W(16)) if_m  ();
    status_cond_unit_if #(.CNT_W(16)) if_nb ();
    status_cond_unit_if #(.CNT_W(4))  if_c4 ();

    status_cond_unit #(.BYPASS(1'b1), .CNT_W(16)) u_main (.clk(clk), .rst(rst), .bus(if_m));
    status_cond_unit #(.BYPASS(1'b0), .CNT_W(16)) u_nb   (.clk(clk), .rst(rst), .bus(if_nb));
    status_cond_unit #(.BYPASS(1'b1), .CNT_W(4))  u_c4   (.clk(clk), .rst(rst), .bus(if_c4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          fld;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    event ev_chk;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(int sel, int fld);
        logic [31:0] r;
        r = '0;
        case (sel)
            SEL_M: case (fld)
                F_PASS: r = 32'(if_m.cond_pass);
                F_CY:   r = 32'(if_m.carry_out);
                F_SR:   r = 32'(if_m.sr);
                default: r = 32'(if_m.fail_count);
            endcase
            SEL_NB: case (fld)
                F_PASS: r = 32'(if_nb.cond_pass);
                F_CY:   r = 32'(if_nb.carry_out);
                F_SR:   r = 32'(if_nb.sr);
                default: r = 32'(if_nb.fail_count);
            endcase
            default: case (fld)
                F_PASS: r = 32'(if_c4.cond_pass);
                F_CY:   r = 32'(if_c4.carry_out);
                F_SR:   r = 32'(if_c4.sr);
                default: r = 32'(if_c4.fail_count);
            endcase
        endcase
        return r;
    endfunction

    // Hand-written reference of the ARM condition table, flags = {Z,C,N,V}
    function automatic logic cond_model(logic [3:0] c, logic [3:0] f);
        logic z, cy, n, v;
        z = f[3]; cy = f[2]; n = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: drains the scoreboard each time the stimulus presents outputs
    initial begin
        chk_t        c;
        logic [31:0] a;
        forever begin
            @(ev_chk);
            while (q.size() > 0) begin
                c = q.pop_front();
                a = actual(c.sel, c.fld);
                checks++;
                if (a !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, expected %0h", c.name, a, c.exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(int sel, int fld, logic [31:0] v, string n);
        chk_t c;
        c.sel = sel; c.fld = fld; c.exp = v; c.name = n;
        q.push_back(c);
    endtask

    task automatic sample();
        -> ev_chk;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] hc_cond [5];
    logic       hc_exp  [5];

    initial begin
        rst = 1'b1;
        if_m.ex_s = 0;  if_m.ex_sr = 0;  if_m.freeze = 0;  if_m.id_valid = 0;  if_m.id_cond = COND_NE;  if_m.cnt_clr = 0;
        if_nb.ex_s = 0; if_nb.ex_sr = 0; if_nb.freeze = 0; if_nb.id_valid = 0; if_nb.id_cond = COND_NE; if_nb.cnt_clr = 0;
        if_c4.ex_s = 0; if_c4.ex_sr = 0; if_c4.freeze = 0; if_c4.id_valid = 0; if_c4.id_cond = COND_NE; if_c4.cnt_clr = 0;

        // Reset state of all instances (NE passes with Z=0)
        step(); step();
        for (int s = 0; s < 3; s++) begin
            push_exp(s, F_SR,   0, $sformatf("reset sr[%0d]", s));
            push_exp(s, F_CY,   0, $sformatf("reset carry[%0d]", s));
            push_exp(s, F_CNT,  0, $sformatf("reset count[%0d]", s));
            push_exp(s, F_PASS, 1, $sformatf("reset pass NE[%0d]", s));
        end
        sample();
        rst = 1'b0;

        // Write then hold
        step();
        if_m.ex_s = 1; if_m.ex_sr = 4'b0100;
        step();
        if_m.ex_s = 0; if_m.ex_sr = 4'b1000;
        push_exp(SEL_M, F_SR, 4'b0100, "write sr");
        push_exp(SEL_M, F_CY, 1,       "write carry");
        sample();
        step();
        push_exp(SEL_M, F_SR, 4'b0100, "hold sr");
        push_exp(SEL_M, F_CY, 1,       "hold carry");
        sample();

        // Build sr=1111, fail_count=5 then reset between edges
        if_m.ex_s = 1; if_m.ex_sr = 4'b1111;
        step();
        if_m.ex_s = 0; if_m.id_valid = 1; if_m.id_cond = COND_NV;
        repeat (5) step();
        if_m.id_valid = 0;
        push_exp(SEL_M, F_SR,  4'b1111, "pre-reset sr");
        push_exp(SEL_M, F_CNT, 5,       "pre-reset count");
        sample();
        #2;
        if_m.id_cond = COND_NE;
        rst = 1'b1;
        #1;
        push_exp(SEL_M, F_SR,   0, "async reset sr");
        push_exp(SEL_M, F_CY,   0, "async reset carry");
        push_exp(SEL_M, F_CNT,  0, "async reset count");
        push_exp(SEL_M, F_PASS, 1, "async reset pass NE");
        sample();
        checks++;
        if (if_m.sr !== 4'b0000) begin
            errors++;
            $display("FAIL direct async reset sr: got %0h", if_m.sr);
        end
        checks++;
        if (if_m.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL direct async reset carry: got %0b", if_m.carry_out);
        end
        checks++;
        if (if_m.fail_count !== 16'd0) begin
            errors++;
            $display("FAIL direct async reset count: got %0d", if_m.fail_count);
        end
        step();
        rst = 1'b0;

        // Bypass versus registered flags
        step();
        if_m.ex_s = 1;  if_m.ex_sr = 4'b1000;  if_m.id_cond = COND_EQ;
        if_nb.ex_s = 1; if_nb.ex_sr = 4'b1000; if_nb.id_cond = COND_EQ;
        #1;
        push_exp(SEL_M,  F_PASS, 1, "bypass EQ same cycle");
        push_exp(SEL_NB, F_PASS, 0, "no-bypass EQ same cycle");
        sample();
        checks++;
        if (if_m.cond_pass !== 1'b1) begin
            errors++;
            $display("FAIL direct bypass EQ: got %0b", if_m.cond_pass);
        end
        checks++;
        if (if_nb.cond_pass !== 1'b0) begin
            errors++;
            $display("FAIL direct no-bypass EQ: got %0b", if_nb.cond_pass);
        end
        step();
        if_m.ex_s = 0; if_nb.ex_s = 0;
        #1;
        push_exp(SEL_NB, F_PASS, 1,       "no-bypass EQ after edge");
        push_exp(SEL_NB, F_SR,   4'b1000, "no-bypass sr");
        push_exp(SEL_M,  F_SR,   4'b1000, "bypass sr");
        sample();

        // Full condition sweep via the bypass path
        if_m.ex_s = 1;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                if_m.ex_sr = 4'(f); if_m.id_cond = 4'(c);
                #1;
                push_exp(SEL_M, F_PASS, 32'(cond_model(4'(c), 4'(f))), $sformatf("sweep cond=%0h flags=%0h", c, f));
                sample();
            end
        end

        // Hand-checked points with N=1, V=0
        hc_cond[0] = COND_GE; hc_exp[0] = 0;
        hc_cond[1] = COND_LT; hc_exp[1] = 1;
        hc_cond[2] = COND_LE; hc_exp[2] = 1;
        hc_cond[3] = COND_NV; hc_exp[3] = 0;
        hc_cond[4] = COND_GT; hc_exp[4] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if_m.ex_sr = 4'b0010; if_m.id_cond = hc_cond[i];
            #1;
            push_exp(SEL_M, F_PASS, 32'(hc_exp[i]), $sformatf("N=1,V=0 cond=%0h", hc_cond[i]));
            sample();
        end

        // Freeze: write and count blocked, condition uses sr_q (C=1 -> CC fails)
        step();
        if_m.ex_s = 1; if_m.ex_sr = 4'b0100; if_m.id_valid = 0;
        step();
        if_m.freeze = 1; if_m.ex_sr = 4'b0001; if_m.id_valid = 1; if_m.id_cond = COND_CC;
        #1;
        push_exp(SEL_M, F_PASS, 0, "freeze pass uses sr_q");
        sample();
        step();
        push_exp(SEL_M, F_SR,  4'b0100, "freeze sr hold");
        push_exp(SEL_M, F_CNT, 0,       "freeze count hold");
        push_exp(SEL_M, F_CY,  1,       "freeze carry");
        sample();
        checks++;
        if (if_m.sr !== 4'b0100) begin
            errors++;
            $display("FAIL direct freeze sr hold: got %0h", if_m.sr);
        end

        // Simultaneous write and failing condition (VC fails on bypassed V=1)
        if_m.freeze = 0; if_m.id_cond = COND_VC;
        #1;
        push_exp(SEL_M, F_PASS, 0, "simul pass bypassed");
        sample();
        step();
        if_m.ex_s = 0; if_m.id_valid = 0;
        #1;
        push_exp(SEL_M, F_SR,  4'b0001, "simul sr");
        push_exp(SEL_M, F_CNT, 1,       "simul count");
        push_exp(SEL_M, F_CY,  0,       "simul carry");
        sample();

        // Saturation and clear on the 4-bit counter
        if_c4.id_valid = 1; if_c4.id_cond = COND_NV;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1 || i == 14 || i == 15 || i == 20) begin
                push_exp(SEL_C4, F_CNT, 32'((i > 15) ? 15 : i), $sformatf("sat count after %0d", i));
                sample();
            end
        end
        checks++;
        if (if_c4.fail_count !== 4'd15) begin
            errors++;
            $display("FAIL direct saturation: got %0d", if_c4.fail_count);
        end
        if_c4.cnt_clr = 1;
        step();
        if_c4.cnt_clr = 0;
        push_exp(SEL_C4, F_CNT, 0, "clear with failing cond");
        sample();
        step();
        step();
        push_exp(SEL_C4, F_CNT, 2, "count after clear");
        sample();
        if_c4.freeze = 1; if_c4.cnt_clr = 1;
        step();
        if_c4.cnt_clr = 0;
        push_exp(SEL_C4, F_CNT, 0, "clear under freeze");
        sample();
        checks++;
        if (if_c4.fail_count !== 4'd0) begin
            errors++;
            $display("FAIL direct clear under freeze: got %0d", if_c4.fail_count);
        end
        step();
        push_exp(SEL_C4, F_CNT, 0, "freeze holds count");
        sample();

        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
`default_nettype wire
